mdio_master: RTL and testbench
==============================

# mdio_master

Management-interface controller for the RMII Ethernet PHY on the board. It accepts single register read/write requests from the on-chip Ethernet/peripheral register block and serialises each one as an IEEE 802.3 clause-22 MDIO frame on the PHY's MDC/MDIO pins. Read results and an error flag are returned on a one-cycle response strobe. It sits between the peripheral bus slave and the chip_top `o_emdc`/`io_emdio` pads. The pad-level tristate buffer lives outside this block.

## Interface
- `CLK_DIV`, default 20: number of `clk` cycles per MDC half-period. Legal values are ≥ 2. One bit period is 2·CLK_DIV cycles.
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_phy` in 5: PHY address.
- `req_reg` in 5: register address.
- `req_wdata` in 16: write data. Ignored for reads.
- `rsp_valid` out 1: one-cycle pulse when a frame completes.
- `rsp_rdata` out 16: read data. 0 for writes. Held until the next `rsp_valid`.
- `rsp_err` out 1: read turnaround error. Held until the next `rsp_valid`.
- `mdc` out 1: management clock to the PHY.
- `mdio_o` out 1: MDIO output value.
- `mdio_oe` out 1: MDIO output enable. 1 = drive.
- `mdio_i` in 1: MDIO pad input.

## Operation
- **Reset values:** `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mdc`=0, `mdio_o`=1, `mdio_oe`=0, state IDLE.
- **Accept:** a request is accepted on a `clk` edge where `req_valid && req_ready`.
  - All request fields are latched on that edge.
  - `req_ready` is 1 only in IDLE, so the block holds at most one outstanding request.
- **Frame format:** 64 bits, sent MSB-first per field.
  - Preamble: 32 × `1`.
  - ST: `01`.
  - OP: `01` for write, `10` for read.
  - PHYAD: 5 bits. REGAD: 5 bits.
  - TA: write drives `10`; read releases the line (`mdio_oe`=0).
  - DATA: 16 bits. Write drives `req_wdata`; read samples into a shift register with `mdio_oe`=0.
- **Gap bit:** after DATA, one extra bit period with `mdio_oe`=0 and MDC still toggling (GAP state).
- **States and transitions:**
  - IDLE → PRE on accept.
  - PRE (32 bits) → HDR (14 bits: ST, OP, PHY, REG) → TA (2 bits) → DATA (16 bits) → GAP (1 bit) → IDLE.
- **Counters:**
  - A 6-bit bit counter counts down within each state.
  - A divider counter of width clog2(CLK_DIV) wraps at CLK_DIV−1 and toggles `mdc` on each wrap.
- **Read error check:** on the second TA bit the PHY must drive 0. If `mdio_i` sampled there is 1, `rsp_err`=1.
  - The frame still runs to completion.
  - `rsp_rdata` returns whatever was sampled; with no PHY present this is 0xFFFF.
- **Write response:** writes always return `rsp_err`=0 and `rsp_rdata`=0.
- **Reset mid-frame:** at the next `clk` edge with `rst`=1, all outputs return to reset values.
  - The frame is aborted and no `rsp_valid` is produced.
  - Latched request data is discarded.
- **Idle bus:** outside a frame `mdc` is held low and MDIO is released.

## Timing
- **Bit period:** each bit occupies 2·CLK_DIV cycles.
  - First CLK_DIV cycles: `mdc`=0. Remaining CLK_DIV cycles: `mdc`=1.
- **Driving:** `mdio_o`/`mdio_oe` change only in the cycle in which `mdc` goes (or stays) low at the start of a bit. Data is therefore stable for CLK_DIV cycles before the MDC rising edge.
- **Sampling:** `mdio_i` is registered on the `clk` edge that sets `mdc` 0→1.
- **Accept to first bit:** if a request is accepted on edge T, the first preamble bit's low phase starts in cycle T+1 with `mdio_oe`=1, `mdio_o`=1.
- **Completion:** `rsp_valid`=1 in cycle T+1+65·2·CLK_DIV, which is T+2601 for CLK_DIV=20.
  - `rsp_rdata`/`rsp_err` are valid in that same cycle.
  - `req_ready` rises in the same cycle as `rsp_valid`, so a new request can be accepted on that edge.
- **Back-to-back:** a request accepted on the `rsp_valid` edge starts its frame the following cycle; there is no extra idle cycle.
- **Latency:** fixed. It is the same for reads and writes and independent of data values.

## Test plan
- **Write:** write PHY 1, reg 0, data 0x1140, CLK_DIV=20.
  - Decode `mdio_o` at MDC rising edges: 32 ones, then `0101 00001 00000 10 0001000101000000`.
  - `mdio_oe`=0 during GAP.
  - `rsp_valid` at T+2601 with `rsp_err`=0 and `rsp_rdata`=0.
- **Read with PHY model:** read PHY 3, reg 2; the PHY model drives TA `z0` and data 0x796D on MDC rising edges.
  - `mdio_oe`=0 from TA onward.
  - Response: `rsp_rdata`=0x796D, `rsp_err`=0.
- **Read with no PHY:** `mdio_i` held at 1.
  - Response: `rsp_err`=1, `rsp_rdata`=0xFFFF.
  - Frame length is unchanged.
- **Back-to-back requests:** hold `req_valid`=1 for two requests.
  - `req_ready`=0 throughout frame 1.
  - The second request is accepted on the `rsp_valid` edge of frame 1.
  - The second frame's preamble starts the next cycle.
- **Reset mid-frame:** assert `rst` for 1 cycle during HDR bit 5.
  - Next cycle: `mdc`=0, `mdio_oe`=0, `req_ready`=1.
  - No `rsp_valid` for the aborted frame; a new request then completes normally.
- **Minimum divider:** with CLK_DIV=2, a read completes with `rsp_valid` at T+261.
  - `mdc` period is 4 cycles, with a 50% duty cycle, throughout the frame.

Source files
------------

// File: rtl/mdio_master.sv
// mdio_master: serialises single clause-22 register read/write requests as
// 64-bit MDIO frames (plus one release bit) on MDC/MDIO and returns the
// result on a one-cycle response strobe.
module mdio_master #(
  parameter int CLK_DIV = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [5:0]       w_bitcnt_load;

  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_bitcnt;
  logic             r_mdc;
  logic             r_mdio_o;
  logic             r_mdio_oe;
  logic             r_write;
  logic [31:0]      r_tx;
  logic [15:0]      r_rx;
  logic             r_ta_err;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_accept;
  logic             w_busy;
  logic             w_wrap;
  logic             w_rise;
  logic             w_bit_end;
  logic             w_last;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_busy    = (r_state != S_IDLE);
  assign w_wrap    = (r_div == DIV_LAST);
  // The divider wrap while MDC is low raises MDC (sample point); the wrap
  // while MDC is high drops it and closes the current bit.
  assign w_rise    = w_busy && w_wrap && !r_mdc;
  assign w_bit_end = w_busy && w_wrap && r_mdc;
  assign w_last    = (r_bitcnt == 6'd0);

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mdc       = r_mdc;
  assign mdio_o    = r_mdio_o;
  assign mdio_oe   = r_mdio_oe;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: each field state advances when its last bit closes; also
  // selects the bit-count reload for the state being entered.
  always_comb begin
    w_state_next  = r_state;
    w_bitcnt_load = 6'd0;
    case (r_state)
      S_IDLE:  if (req_valid)            w_state_next = S_PRE;
      S_PRE:   if (w_bit_end && w_last)  w_state_next = S_HDR;
      S_HDR:   if (w_bit_end && w_last)  w_state_next = S_TA;
      S_TA:    if (w_bit_end && w_last)  w_state_next = S_DATA;
      S_DATA:  if (w_bit_end && w_last)  w_state_next = S_GAP;
      S_GAP:   if (w_bit_end && w_last)  w_state_next = S_IDLE;
      default:                           w_state_next = S_IDLE;
    endcase
    case (w_state_next)
      S_PRE:   w_bitcnt_load = 6'd31;
      S_HDR:   w_bitcnt_load = 6'd13;
      S_TA:    w_bitcnt_load = 6'd1;
      S_DATA:  w_bitcnt_load = 6'd15;
      default: w_bitcnt_load = 6'd0;
    endcase
  end

  // Datapath: MDC divider, bit counter, serialiser, read sampler, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_bitcnt    <= 6'd0;
      r_mdc       <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_oe   <= 1'b0;
      r_write     <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_ta_err    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        // Everything after the preamble: ST, OP, PHYAD, REGAD, TA, DATA.
        r_write   <= req_write;
        r_tx      <= {2'b01, (req_write ? 2'b01 : 2'b10), req_phy, req_reg,
                      2'b10, req_wdata};
        r_bitcnt  <= 6'd31;
        r_div     <= '0;
        r_mdc     <= 1'b0;
        r_mdio_o  <= 1'b1;
        r_mdio_oe <= 1'b1;
        r_rx      <= '0;
        r_ta_err  <= 1'b0;
      end else if (w_busy) begin
        if (w_wrap) begin
          r_div <= '0;
          r_mdc <= ~r_mdc;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end

        if (w_rise) begin
          // The PHY must pull the second TA bit low; a high level means no PHY answered.
          if (r_state == S_TA && w_last) r_ta_err <= mdio_i;
          if (r_state == S_DATA)         r_rx     <= {r_rx[14:0], mdio_i};
        end

        if (w_bit_end) begin
          r_bitcnt <= w_last ? w_bitcnt_load : r_bitcnt - 6'd1;
          // Drive the upcoming bit while MDC goes low.
          case (w_state_next)
            S_PRE: begin
              r_mdio_o  <= 1'b1;
              r_mdio_oe <= 1'b1;
            end
            S_HDR: begin
              r_mdio_o  <= r_tx[31];
              r_mdio_oe <= 1'b1;
              r_tx      <= {r_tx[30:0], 1'b0};
            end
            S_TA, S_DATA: begin
              r_mdio_o  <= r_write ? r_tx[31] : 1'b1;
              r_mdio_oe <= r_write;
              r_tx      <= {r_tx[30:0], 1'b0};
            end
            default: begin
              r_mdio_o  <= 1'b1;
              r_mdio_oe <= 1'b0;
            end
          endcase
          if (r_state == S_GAP && w_last) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_write ? 16'h0000 : r_rx;
            r_rsp_err   <= r_write ? 1'b0 : r_ta_err;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: scoreboard bench for mdio_master. Instance A runs with the
// default divider, instance B with the minimum divider of 2.
module tb_mdio_master;

  localparam int DIV_A = 20;
  localparam int DIV_B = 2;
  localparam int LAT_A = 130 * DIV_A;
  localparam int LAT_B = 130 * DIV_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic        a_rst = 1'b1;
  logic        a_req_valid = 1'b0;
  logic        a_req_ready;
  logic        a_req_write = 1'b0;
  logic [4:0]  a_req_phy = 5'd0;
  logic [4:0]  a_req_reg = 5'd0;
  logic [15:0] a_req_wdata = 16'h0;
  logic        a_rsp_valid;
  logic [15:0] a_rsp_rdata;
  logic        a_rsp_err;
  logic        a_mdc;
  logic        a_mdio_o;
  logic        a_mdio_oe;
  logic        a_mdio_i = 1'b1;

  // Instance B signals
  logic        b_rst = 1'b1;
  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_req_write = 1'b0;
  logic [4:0]  b_req_phy = 5'd0;
  logic [4:0]  b_req_reg = 5'd0;
  logic [15:0] b_req_wdata = 16'h0;
  logic        b_rsp_valid;
  logic [15:0] b_rsp_rdata;
  logic        b_rsp_err;
  logic        b_mdc;
  logic        b_mdio_o;
  logic        b_mdio_oe;
  logic        b_mdio_i = 1'b1;

  mdio_master #(.CLK_DIV(DIV_A)) dut_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_phy(a_req_phy), .req_reg(a_req_reg), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mdc(a_mdc), .mdio_o(a_mdio_o), .mdio_oe(a_mdio_oe), .mdio_i(a_mdio_i)
  );

  mdio_master #(.CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_phy(b_req_phy), .req_reg(b_req_reg), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mdc(b_mdc), .mdio_o(b_mdio_o), .mdio_oe(b_mdio_oe), .mdio_i(b_mdio_i)
  );

  // Record MDIO line state at every MDC rising edge of instance A; after a
  // frame, bit 64 holds the first preamble bit and bit 0 the GAP bit.
  logic [64:0] a_cap_o  = '0;
  logic [64:0] a_cap_oe = '0;
  always @(posedge a_mdc) begin
    a_cap_o  <= {a_cap_o[63:0], a_mdio_o};
    a_cap_oe <= {a_cap_oe[63:0], a_mdio_oe};
  end

  // Scoreboard queues
  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  string       obs_name[$];
  logic [63:0] obs_act[$];
  logic [63:0] obs_want[$];

  int checks = 0;
  int errors = 0;

  function automatic void compare(input string name, input logic [63:0] act,
                                  input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Monitor: compares observations handed over by the stimulus and every
  // response strobe against the expectation queued when the request went in.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (obs_name.size() > 0)
      compare(obs_name.pop_front(), obs_act.pop_front(), obs_want.pop_front());
    if (a_rsp_valid) begin
      $display("A rsp: rdata=0x%h err=%0b cycle=%0d", a_rsp_rdata, a_rsp_err, cyc);
      compare("A response was expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        compare("A rsp_rdata", 64'(a_rsp_rdata), 64'(e.rdata));
        compare("A rsp_err", 64'(a_rsp_err), 64'(e.err));
        compare("A rsp cycle", 64'(cyc), 64'(e.due));
      end
    end
    if (b_rsp_valid) begin
      $display("B rsp: rdata=0x%h err=%0b cycle=%0d", b_rsp_rdata, b_rsp_err, cyc);
      compare("B response was expected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        compare("B rsp_rdata", 64'(b_rsp_rdata), 64'(e.rdata));
        compare("B rsp_err", 64'(b_rsp_err), 64'(e.err));
        compare("B rsp cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic note(input string name, input logic [63:0] act, input logic [63:0] want);
    obs_name.push_back(name);
    obs_act.push_back(act);
    obs_want.push_back(want);
  endtask

  task automatic expect_rsp(input bit sel, input logic [15:0] rdata, input logic err,
                            input int due);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.due   = due;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  // Present a request and return the clock edge on which it was accepted.
  task automatic issue(input bit sel, input bit wr, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd, input bit hold,
                       output int t_acc, output int waited);
    string p;
    p = sel ? "B" : "A";
    @(negedge clk);
    if (sel) begin
      b_req_valid = 1'b1; b_req_write = wr; b_req_phy = phy; b_req_reg = rg; b_req_wdata = wd;
    end else begin
      a_req_valid = 1'b1; a_req_write = wr; a_req_phy = phy; a_req_reg = rg; a_req_wdata = wd;
    end
    waited = 0;
    while (!(sel ? b_req_ready : a_req_ready) && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    note({p, " req_ready before accept"}, 64'(sel ? b_req_ready : a_req_ready), 64'd1);
    @(posedge clk);
    #1;
    t_acc = cyc;
    $display("%s req: write=%0b phy=%0d reg=%0d wdata=0x%h accepted at edge %0d",
             p, wr, phy, rg, wd, t_acc);
    if (!hold) begin
      if (sel) b_req_valid = 1'b0;
      else     a_req_valid = 1'b0;
    end
  endtask

  // First cycle after accept: low phase of the first preamble bit, driven 1.
  task automatic check_first(input bit sel);
    @(negedge clk);
    if (sel) note("B first bit {mdc,oe,o}", 64'({b_mdc, b_mdio_oe, b_mdio_o}), 64'b011);
    else     note("A first bit {mdc,oe,o}", 64'({a_mdc, a_mdio_oe, a_mdio_o}), 64'b011);
  endtask

  task automatic wait_rsp(input bit sel);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? b_rsp_valid : a_rsp_valid) && n < 3000);
    note(sel ? "B rsp_valid arrives" : "A rsp_valid arrives",
         64'(sel ? b_rsp_valid : a_rsp_valid), 64'd1);
  endtask

  // PHY model for instance A: after MDC rise n it drives the value for bit n+1
  // (TA second bit low, then the 16 data bits MSB first), then releases.
  task automatic phy_read(input logic [15:0] data);
    int   r;
    int   n;
    logic prev;
    r = 0;
    n = 0;
    prev = 1'b0;
    while (r < 64 && n < 3000) begin
      @(negedge clk);
      n++;
      if (a_mdc && !prev) begin
        if (r == 46)                 a_mdio_i = 1'b0;
        else if (r >= 47 && r <= 62) a_mdio_i = data[62 - r];
        else if (r == 63)            a_mdio_i = 1'b1;
        r++;
      end
      prev = a_mdc;
    end
    note("A PHY model saw 64 MDC rises", 64'(r), 64'd64);
  endtask

  logic [21:0] reset_want;
  logic [63:0] wr_frame;
  logic [45:0] rd_head;

  initial begin : stimulus
    int t1;
    int t2;
    int w;
    int bad;
    logic want_mdc;

    reset_want = {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    wr_frame   = 64'hFFFF_FFFF_5082_1140;
    rd_head    = {32'hFFFF_FFFF, 14'h1862};

    // Reset values
    repeat (3) @(negedge clk);
    note("A reset {ready,valid,rdata,err,mdc,o,oe}",
         64'({a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_mdc, a_mdio_o, a_mdio_oe}),
         64'(reset_want));
    note("B reset {ready,valid,rdata,err,mdc,o,oe}",
         64'({b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_mdc, b_mdio_o, b_mdio_oe}),
         64'(reset_want));
    a_rst = 1'b0;
    b_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write PHY 1 reg 0 data 0x1140
    issue(1'b0, 1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, t1, w);
    expect_rsp(1'b0, 16'h0000, 1'b0, t1 + LAT_A);
    check_first(1'b0);
    wait_rsp(1'b0);
    note("A write frame bits", a_cap_o[64:1], wr_frame);
    note("A write frame oe", a_cap_oe[64:1], 64'hFFFF_FFFF_FFFF_FFFF);
    note("A write GAP oe", 64'(a_cap_oe[0]), 64'd0);

    // Read PHY 3 reg 2 with the PHY answering 0x796D
    issue(1'b0, 1'b0, 5'd3, 5'd2, 16'hDEAD, 1'b0, t1, w);
    expect_rsp(1'b0, 16'h796D, 1'b0, t1 + LAT_A);
    phy_read(16'h796D);
    wait_rsp(1'b0);
    note("A read header bits", 64'(a_cap_o[64:19]), 64'(rd_head));
    note("A read frame oe", a_cap_oe[64:1], 64'hFFFF_FFFF_FFFC_0000);
    note("A read GAP oe", 64'(a_cap_oe[0]), 64'd0);

    // Read with no PHY: line pulled high
    a_mdio_i = 1'b1;
    issue(1'b0, 1'b0, 5'd31, 5'd17, 16'h0000, 1'b0, t1, w);
    expect_rsp(1'b0, 16'hFFFF, 1'b1, t1 + LAT_A);
    wait_rsp(1'b0);

    // Back-to-back: valid held high across two requests
    issue(1'b0, 1'b1, 5'd5, 5'd4, 16'hA5A5, 1'b1, t1, w);
    expect_rsp(1'b0, 16'h0000, 1'b0, t1 + LAT_A);
    issue(1'b0, 1'b0, 5'd7, 5'd1, 16'h0000, 1'b0, t2, w);
    expect_rsp(1'b0, 16'hFFFF, 1'b1, t2 + LAT_A);
    note("A req_ready low cycles in frame 1", 64'(w), 64'(LAT_A));
    note("A second accept edge", 64'(t2), 64'(t1 + LAT_A + 1));
    check_first(1'b0);
    wait_rsp(1'b0);

    // Reset during HDR bit 5 (frame bit 37), then a normal frame
    issue(1'b0, 1'b1, 5'd2, 5'd9, 16'h1234, 1'b0, t1, w);
    while (cyc < t1 + 1490) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    note("A after mid-frame reset {ready,mdc,oe,valid,err,rdata}",
         64'({a_req_ready, a_mdc, a_mdio_oe, a_rsp_valid, a_rsp_err, a_rsp_rdata}),
         64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
    a_rst = 1'b0;
    while (cyc < t1 + LAT_A + 100) @(negedge clk);
    issue(1'b0, 1'b0, 5'd4, 5'd3, 16'h0000, 1'b0, t1, w);
    expect_rsp(1'b0, 16'hFFFF, 1'b1, t1 + LAT_A);
    wait_rsp(1'b0);

    // Minimum divider: read, MDC period 4 with 50% duty throughout
    issue(1'b1, 1'b0, 5'd8, 5'd30, 16'h0000, 1'b0, t1, w);
    expect_rsp(1'b1, 16'hFFFF, 1'b1, t1 + LAT_B);
    bad = 0;
    for (int k = 1; k <= LAT_B; k++) begin
      @(negedge clk);
      want_mdc = 1'(((k - 1) / 2) % 2);
      if (k == 1 && (b_mdio_oe !== 1'b1 || b_mdio_o !== 1'b1)) bad++;
      if (b_mdc !== want_mdc) bad++;
    end
    note("B mdc pattern errors", 64'(bad), 64'd0);
    wait_rsp(1'b1);

    repeat (4) @(negedge clk);
    note("A outstanding expectations", 64'(qa.size()), 64'd0);
    note("B outstanding expectations", 64'(qb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
